siggen_sequencer: RTL

- Controller that sequences the DAC signal generator through a programmable list of waveform segments.
- Segment types: sine, triangle, sawtooth, reverse sawtooth.
- Owns the generator's config word and its reset. The generator latches config only while in reset, so each segment switch is a short reset pulse with new config.
- Counts whole phase periods from the DDS phase stream to time each segment. Sits between the PS register interface and the generator.

---
 rtl/siggen_sequencer_if.sv | 44 ++++
 rtl/siggen_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/siggen_sequencer_if.sv
// siggen_sequencer_if: control, table-write, phase and generator-side signals
// of the signal-generator sequencer. master = PS/testbench side, slave = sequencer.
// Optional macro SIGGEN_SEQ_REPEAT_EN adds the repeat_count field.
interface siggen_sequencer_if #(
    parameter int DEPTH_LOG2     = 3,
    parameter int CFG_DATA_WIDTH = 64,
    parameter int PHASE_WIDTH    = 16
);
    logic                      start;
    logic                      stop;
    logic                      loop_en;
    logic [DEPTH_LOG2:0]       num_entries;
    logic                      wr_en;
    logic [DEPTH_LOG2-1:0]     wr_addr;
    logic [CFG_DATA_WIDTH-1:0] wr_data;
    logic [PHASE_WIDTH-1:0]    phase;
    logic                      phase_valid;
`ifdef SIGGEN_SEQ_REPEAT_EN
    logic [15:0]               repeat_count;
`endif
    logic [CFG_DATA_WIDTH-1:0] cfg_data;
    logic                      gen_resetn;
    logic                      busy;
    logic                      done;
    logic [DEPTH_LOG2-1:0]     seg_idx;

    modport master (
`ifdef SIGGEN_SEQ_REPEAT_EN
        output repeat_count,
`endif
        output start, stop, loop_en, num_entries,
        output wr_en, wr_addr, wr_data, phase, phase_valid,
        input  cfg_data, gen_resetn, busy, done, seg_idx
    );

    modport slave (
`ifdef SIGGEN_SEQ_REPEAT_EN
        input  repeat_count,
`endif
        input  start, stop, loop_en, num_entries,
        input  wr_en, wr_addr, wr_data, phase, phase_valid,
        output cfg_data, gen_resetn, busy, done, seg_idx
    );
endinterface

// File: rtl/siggen_sequencer.sv
// siggen_sequencer: steps the DAC signal generator through a table of waveform
// segments. Each segment switch is a RST_CYCLES-long generator reset with the new
// config word, then waits for a phase wrap and counts whole periods.
// Optional macro SIGGEN_SEQ_REPEAT_EN: repeat the whole list repeat_count+1 times.
// Table entries must be at least 64 bits wide (period count lives in [63:48]).
module siggen_sequencer #(
    parameter int DEPTH_LOG2     = 3,
    parameter int CFG_DATA_WIDTH = 64,
    parameter int PHASE_WIDTH    = 16,
    parameter int RST_CYCLES     = 2
) (
    input  logic               clk,
    input  logic               aresetn,
    siggen_sequencer_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int RCW   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0]            RC_LAST  = RCW'(RST_CYCLES - 1);
    localparam logic [RCW-1:0]            RC_ONE   = RCW'(1);
    localparam logic [DEPTH_LOG2-1:0]     IDX_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]       NE_ONE   = (DEPTH_LOG2 + 1)'(1);
    // Generator word: type [3:0], A [31:16], AIncrement [47:32]; everything else 0.
    localparam logic [CFG_DATA_WIDTH-1:0] CFG_MASK = CFG_DATA_WIDTH'(64'h0000_FFFF_FFFF_000F);

    typedef enum logic [1:0] {IDLE, LOAD, ARM, RUN} state_t;

    state_t                    state, state_n;
    logic [CFG_DATA_WIDTH-1:0] tbl [DEPTH];
    logic [CFG_DATA_WIDTH-1:0] cfg_q;
    logic [DEPTH_LOG2-1:0]     seg_q, seg_n;
    logic [DEPTH_LOG2:0]       nxt_ext;
    logic [15:0]               per_cnt, ld_per;
    logic [RCW-1:0]            rst_cnt;
    logic                      prev_msb, wrap, seg_end, more, rep_more;
    logic                      load, done_n, done_q;

    // wrap = valid sample whose MSB fell relative to the previous valid sample
    assign wrap    = bus.phase_valid & prev_msb & ~bus.phase[PHASE_WIDTH-1];
    assign seg_end = (state == RUN) & wrap & (per_cnt == 16'd1);
    // Next index exists only if it is below num_entries; a shrunken num_entries
    // (seg_idx >= num_entries) falls into end-of-list here as well.
    assign nxt_ext = {1'b0, seg_q} + NE_ONE;
    assign more    = (nxt_ext < bus.num_entries);
    assign ld_per  = tbl[seg_n][63:48];

`ifdef SIGGEN_SEQ_REPEAT_EN
    logic [15:0] rep_left;
    logic        rep_dec;
    assign rep_more = (rep_left != 16'd0);
    assign rep_dec  = seg_end & ~more & ~bus.loop_en & rep_more & ~bus.stop;

    // Remaining list repeats: sampled at start, consumed at each end-of-list restart
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)                     rep_left <= '0;
        else if (state == IDLE && load)   rep_left <= bus.repeat_count;
        else if (rep_dec)                 rep_left <= rep_left - 16'd1;
    end
`else
    assign rep_more = 1'b0;
`endif

    // Segment table: plain register array, never reset, writable in any state
    always_ff @(posedge clk) begin
        if (bus.wr_en) tbl[bus.wr_addr] <= bus.wr_data;
    end

    // State register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_n;
    end

    // Next state, next segment index, load strobe and done pulse
    always_comb begin
        state_n = state;
        seg_n   = seg_q;
        load    = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: if (bus.start && bus.num_entries != '0) begin
                state_n = LOAD;
                seg_n   = '0;
                load    = 1'b1;
            end
            LOAD: if (rst_cnt == RC_LAST) state_n = ARM;
            ARM:  if (wrap) state_n = RUN;
            RUN:  if (seg_end) begin
                if (more) begin
                    state_n = LOAD;
                    seg_n   = seg_q + IDX_ONE;
                    load    = 1'b1;
                end else if (bus.loop_en || rep_more) begin
                    state_n = LOAD;
                    seg_n   = '0;
                    load    = 1'b1;
                end else begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // stop overrides everything and leaves seg_idx where it was
        if (bus.stop) begin
            state_n = (state == IDLE && !(bus.start && bus.num_entries != '0)) ? IDLE : IDLE;
            seg_n   = seg_q;
            load    = 1'b0;
            done_n  = 1'b0;
        end
    end

    // Datapath: config word, period counter, reset-pulse timer, wrap history
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            seg_q    <= '0;
            cfg_q    <= '0;
            per_cnt  <= '0;
            rst_cnt  <= '0;
            prev_msb <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            seg_q  <= seg_n;
            done_q <= done_n;
            // Config and periods are captured on entry to LOAD so they are already
            // stable during the whole generator reset pulse.
            if (load) begin
                cfg_q   <= tbl[seg_n] & CFG_MASK;
                per_cnt <= (ld_per == 16'd0) ? 16'd1 : ld_per;
            end else if (state == RUN && wrap) begin
                per_cnt <= per_cnt - 16'd1;
            end
            rst_cnt <= (state == LOAD && state_n == LOAD) ? rst_cnt + RC_ONE : '0;
            if (state == IDLE)        prev_msb <= 1'b0;
            else if (bus.phase_valid) prev_msb <= bus.phase[PHASE_WIDTH-1];
        end
    end

    assign bus.cfg_data   = cfg_q;
    assign bus.gen_resetn = (state == ARM) || (state == RUN);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_q;
    assign bus.seg_idx    = seg_q;
endmodule
